// File: rtl/synth_voices.sv
// Multi-voice tone generator: a time-multiplexed mixer that walks every voice once per
// audio sample, followed by a first-order sigma-delta DAC running at the full clock rate.
module synth_voices #(
    parameter int NUM_VOICES        = 4,
    parameter int SAMPLE_DIV_LOG2   = 10,
    parameter int TICK_SAMPLES_LOG2 = 8,
    parameter int INC_W             = 12,
    localparam int VW               = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
    input  logic             clk48,
    input  logic             rst_n,
    input  logic             trig_valid,
    output logic             trig_ready,
    input  logic [VW-1:0]    trig_voice,
    input  logic [INC_W-1:0] trig_inc,
    input  logic [1:0]       trig_wave,
    input  logic [3:0]       trig_vol,
    input  logic             trig_decay,
    output logic             sample_strobe,
    output logic [15:0]      audio_sample,
    output logic             out
);

    localparam int ACC_W = 16 + $clog2(NUM_VOICES);
    localparam logic [VW:0] NV_EXT = (VW+1)'(NUM_VOICES);
    localparam logic [VW-1:0] LAST_VOICE = VW'(NUM_VOICES - 1);
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_LO = ACC_W'(-32768);

    typedef enum logic {IDLE, MIX} state_t;

    state_t                        state_q, state_d;
    logic [SAMPLE_DIV_LOG2-1:0]    div_q, div_d;
    logic [TICK_SAMPLES_LOG2-1:0]  samp_q, samp_d;
    logic                          tick_q, tick_d;
    logic [VW-1:0]                 vidx_q, vidx_d;
    logic signed [ACC_W-1:0]       acc_q, acc_d;
    logic [14:0]                   lfsr_q, lfsr_d;
    logic                          ready_q, ready_d;
    logic                          strobe_q, strobe_d;
    logic [15:0]                   audio_q, audio_d;
    logic [15:0]                   sd_q, sd_d;
    logic                          out_q, out_d;

    logic [15:0]      phase_q [NUM_VOICES];
    logic [15:0]      phase_d [NUM_VOICES];
    logic [INC_W-1:0] inc_q   [NUM_VOICES];
    logic [INC_W-1:0] inc_d   [NUM_VOICES];
    logic [1:0]       wave_q  [NUM_VOICES];
    logic [1:0]       wave_d  [NUM_VOICES];
    logic [3:0]       vol_q   [NUM_VOICES];
    logic [3:0]       vol_d   [NUM_VOICES];
    logic             decay_q [NUM_VOICES];
    logic             decay_d [NUM_VOICES];

    logic [15:0]              p;
    logic signed [15:0]       tri_pre;
    logic signed [15:0]       wave_s;
    logic signed [15:0]       contrib_s;
    logic signed [ACC_W-1:0]  mix_sum;
    logic [15:0]              sat16;
    logic [16:0]              sd_sum;
    logic                     accept;

    // Waveform of the voice currently selected by the mixer, from its advanced phase.
    always_comb begin
        p       = phase_q[vidx_q] + 16'(inc_q[vidx_q]);
        tri_pre = $signed(p ^ {16{p[15]}}) - 16'sd16384;
        case (wave_q[vidx_q])
            2'd0:    wave_s = p[15] ? -16'sd8192 : 16'sd8192;
            2'd1:    wave_s = tri_pre >>> 1;
            2'd2:    wave_s = $signed({~p[15], p[14:0]}) >>> 2;
            default: wave_s = $signed({3'b000, lfsr_q[12:0]}) - 16'sd4096;
        endcase
        // An arithmetic shift by 15 would leave -1 for negative waves, so mute explicitly.
        contrib_s = (vol_q[vidx_q] == 4'd15) ? 16'sd0 : (wave_s >>> vol_q[vidx_q]);
        mix_sum   = acc_q + ACC_W'(contrib_s);
        if (mix_sum > SAT_HI) begin
            sat16 = 16'h7FFF;
        end else if (mix_sum < SAT_LO) begin
            sat16 = 16'h8000;
        end else begin
            sat16 = mix_sum[15:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        div_d    = div_q + 1'b1;
        samp_d   = samp_q;
        tick_d   = tick_q;
        vidx_d   = vidx_q;
        acc_d    = acc_q;
        lfsr_d   = lfsr_q;
        strobe_d = 1'b0;
        audio_d  = audio_q;
        for (int i = 0; i < NUM_VOICES; i++) begin
            phase_d[i] = phase_q[i];
            inc_d[i]   = inc_q[i];
            wave_d[i]  = wave_q[i];
            vol_d[i]   = vol_q[i];
            decay_d[i] = decay_q[i];
        end

        sd_sum = {1'b0, sd_q} + {1'b0, audio_q};
        sd_d   = sd_sum[15:0];
        out_d  = sd_sum[16];

        accept = trig_valid & ready_q;

        case (state_q)
            IDLE: begin
                if (accept && ({1'b0, trig_voice} < NV_EXT)) begin
                    phase_d[trig_voice] = 16'h0000;
                    inc_d[trig_voice]   = trig_inc;
                    wave_d[trig_voice]  = trig_wave;
                    vol_d[trig_voice]   = trig_vol;
                    decay_d[trig_voice] = trig_decay;
                end
                if (&div_q) begin
                    state_d = MIX;
                    vidx_d  = '0;
                    acc_d   = '0;
                    tick_d  = &samp_q;
                    samp_d  = samp_q + 1'b1;
                end
            end
            MIX: begin
                phase_d[vidx_q] = p;
                if (tick_q && decay_q[vidx_q] && (vol_q[vidx_q] != 4'd15)) begin
                    vol_d[vidx_q] = vol_q[vidx_q] + 4'd1;
                end
                acc_d = mix_sum;
                if (vidx_q == LAST_VOICE) begin
                    state_d  = IDLE;
                    strobe_d = 1'b1;
                    audio_d  = sat16 ^ 16'h8000;
                    lfsr_d   = {lfsr_q[0], lfsr_q[0] ^ lfsr_q[14], lfsr_q[13:1]};
                end else begin
                    vidx_d = vidx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk48 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            div_q    <= '0;
            samp_q   <= '0;
            tick_q   <= 1'b0;
            vidx_q   <= '0;
            acc_q    <= '0;
            lfsr_q   <= 15'h1CAF;
            ready_q  <= 1'b1;
            strobe_q <= 1'b0;
            audio_q  <= 16'h8000;
            sd_q     <= 16'h0000;
            out_q    <= 1'b0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= 16'h0000;
                inc_q[i]   <= '0;
                wave_q[i]  <= 2'd0;
                vol_q[i]   <= 4'd15;
                decay_q[i] <= 1'b0;
            end
        end else begin
            state_q  <= state_d;
            div_q    <= div_d;
            samp_q   <= samp_d;
            tick_q   <= tick_d;
            vidx_q   <= vidx_d;
            acc_q    <= acc_d;
            lfsr_q   <= lfsr_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
            audio_q  <= audio_d;
            sd_q     <= sd_d;
            out_q    <= out_d;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= phase_d[i];
                inc_q[i]   <= inc_d[i];
                wave_q[i]  <= wave_d[i];
                vol_q[i]   <= vol_d[i];
                decay_q[i] <= decay_d[i];
            end
        end
    end

    assign trig_ready    = ready_q;
    assign sample_strobe = strobe_q;
    assign audio_sample  = audio_q;
    assign out           = out_q;

endmodule

// File: doc/synth_voices.md
SYNTH_VOICES -- requirements
Module: synth_voices

Interface
REQ-001 Parameter NUM_VOICES, default 4, meaning number of independent voices; legal range 1..8.
REQ-002 Parameter SAMPLE_DIV_LOG2, default 10, meaning log2 of clk48 cycles per audio sample; legal range 4..12.
REQ-003 Parameter TICK_SAMPLES_LOG2, default 8, meaning log2 of samples per envelope tick.
REQ-004 Parameter INC_W, default 12, meaning width of the per-voice phase increment; legal range 8..15.
REQ-005 Clocking: one clock, clk48; reset rst_n is asynchronous and active-low.
REQ-006 clk48  input  1  system clock.
REQ-007 rst_n  input  1  asynchronous active-low reset.
REQ-008 trig_valid  input  1  trigger request.
REQ-009 trig_ready  output  1  trigger accepted when high together with trig_valid.
REQ-010 trig_voice  input  max(1,clog2(NUM_VOICES))  target voice index.
REQ-011 trig_inc  input  INC_W  phase increment per sample, zero-extended to 16 bits.
REQ-012 trig_wave  input  2  waveform: 0 square, 1 triangle, 2 saw, 3 noise.
REQ-013 trig_vol  input  4  initial attenuation shift; 15 means mute.
REQ-014 trig_decay  input  1  1 enables per-tick envelope decay.
REQ-015 sample_strobe  output  1  one-cycle pulse when audio_sample updates.
REQ-016 audio_sample  output  16  mixed sample, offset-binary (signed mix XOR 0x8000).
REQ-017 out  output  1  first-order sigma-delta bitstream.

Function
REQ-018 Sample divider: free-running SAMPLE_DIV_LOG2-bit counter; terminal count (all ones) starts one MIX pass on the next cycle.
REQ-019 FSM states IDLE and MIX; IDLE->MIX on divider terminal count; MIX lasts exactly NUM_VOICES cycles, voice k processed in MIX cycle k; MIX->IDLE after voice NUM_VOICES-1.
REQ-020 trig_ready is high in IDLE and low in MIX; a trigger with trig_valid high during MIX waits, held by the requester.
REQ-021 On accept: voice registers inc, wave, vol, decay load from trig_*; voice phase clears to 0; takes effect at the next MIX pass.
REQ-022 Trigger accepted on the same cycle as divider terminal count: trigger is applied and included in the MIX pass starting next cycle.
REQ-023 trig_voice >= NUM_VOICES: handshake completes, no state changes.
REQ-024 Per voice in MIX: phase <= phase + inc (16-bit wrap); waveform computed from the updated phase p.
REQ-025 Square: +0x2000 if p[15]=0 else -0x2000.
REQ-026 Triangle: ((p XOR {16{p[15]}}) - 16384) arithmetic-shifted right 1.
REQ-027 Saw: {~p[15], p[14:0]} as signed, arithmetic-shifted right 2.
REQ-028 Noise: {3'b0, lfsr[12:0]} minus 4096, signed.
REQ-029 Voice contribution: waveform arithmetic-shifted right by vol; vol 15 contributes exactly 0.
REQ-030 Mix accumulator 16+clog2(NUM_VOICES) bits signed, cleared at MIX start; after last voice, saturated to [-32768, 32767].
REQ-031 Cycle after the last MIX cycle: audio_sample <= saturated mix XOR 0x8000, sample_strobe high for that one cycle.
REQ-032 Noise LFSR: 15 bits, shared, stepped once per MIX pass at its end: lfsr <= {l[0], l[0]^l[14], l[13:1]}.
REQ-033 Envelope tick: TICK_SAMPLES_LOG2-bit sample counter; on its wrap the MIX pass marks tick; each voice with decay=1 increments vol by 1 during its MIX cycle, saturating at 15.
REQ-034 Sigma-delta every clk48 cycle: acc17 = acc16 + audio_sample; acc16 <= acc17[15:0]; out <= acc17[16].

Reset
REQ-035 On rst_n low: FSM IDLE, dividers 0, trig_ready 1, sample_strobe 0, audio_sample 0x8000, out 0, sigma-delta accumulator 0, lfsr 0x1CAF.
REQ-036 On rst_n low: every voice phase 0, inc 0, wave 0, vol 15, decay 0.
REQ-037 Reset asserted mid-MIX aborts the pass; no partial sample is published.

Verification
REQ-038 Release reset, no triggers, SAMPLE_DIV_LOG2=4 -> sample_strobe every 16 cycles, audio_sample stays 0x8000, out duty 50%.
REQ-039 Trigger voice 0 square, inc 0x800, vol 0 -> audio_sample alternates 0xA000/0x6000, 16 samples per half-period.
REQ-040 All 4 voices square, inc 0, vol 0 (phase stays 0) -> mix 0x8000 saturates to 32767, audio_sample 0xFFFF.
REQ-041 Voice 1 vol 0, decay 1, TICK_SAMPLES_LOG2=2 -> vol rises by 1 every 4 samples, reaches 15 after 60 samples, contribution then 0.
REQ-042 trig_valid held during MIX -> trig_ready low for NUM_VOICES cycles, accept on first IDLE cycle, exactly one load.
REQ-043 rst_n pulsed during MIX -> no sample_strobe for that pass, all outputs at REQ-035 values.
